op_sequencer: RTL and testbench

//  Parametrised multi-step operation sequencer; generalises the START/DELAY/WAIT control FSM.
//  On start, runs N_STEPS steps per iteration, repeated for a runtime iteration count.

---
 rtl/op_sequencer_pkg.sv | 20 ++
 rtl/op_sequencer_cycle_counter.sv | 42 ++++
 rtl/op_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_op_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/op_sequencer_pkg.sv
// Shared state encoding and sizing helper for the op_sequencer block.
// Used by op_sequencer and op_sequencer_cycle_counter.
package op_sequencer_pkg;

    localparam int OPSEQ_W = 3;

    typedef enum logic [OPSEQ_W-1:0] {
        OPSEQ_IDLE       = 3'd0,
        OPSEQ_LOAD_START = 3'd1,
        OPSEQ_LOAD_DELAY = 3'd2,
        OPSEQ_LOAD_WAIT  = 3'd3,
        OPSEQ_DONE       = 3'd4
    } opseq_state_e;

    // Bits needed to count 0 .. n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/op_sequencer_cycle_counter.sv
// Saturating cycle counter: load clears, enable advances, tc flags the
// LIMIT-th counted cycle. Used for the step hold-off and the wait timeout.
module op_sequencer_cycle_counter
    import op_sequencer_pkg::*;
#(
    parameter int LIMIT = 2,
    parameter int W     = cnt_width(LIMIT)
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign tc = (count_q == W'(LIMIT - 1));

    // Next count: stop at the terminal value so tc stays asserted until reload.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = {W{1'b0}};
        end else if (enable && !tc) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/op_sequencer.sv
// Multi-step operation sequencer: N_STEPS go/delay/wait steps per iteration.
// Optional LOAD_WAIT timeout with sticky error is enabled by OPSEQ_TIMEOUT_EN.
module op_sequencer
    import op_sequencer_pkg::*;
#(
    parameter int N_STEPS      = 4,
    parameter int STEP_W       = 2,
    parameter int ITER_W       = 8,
    parameter int DELAY_CYCLES = 2,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ITER_W-1:0] iterations,
    input  logic              step_done,
    output logic              busy,
    output logic              step_go,
    output logic [STEP_W-1:0] step_idx,
    output logic [ITER_W-1:0] iter_idx,
    output logic              finished,
    output logic              error
);

    opseq_state_e      state_q,    state_d;
    logic [ITER_W-1:0] iter_lat_q, iter_lat_d;
    logic [STEP_W-1:0] step_idx_q, step_idx_d;
    logic [ITER_W-1:0] iter_idx_q, iter_idx_d;
    logic              pending_q,  pending_d;
    logic              busy_q,     busy_d;
    logic              step_go_q,  step_go_d;
    logic              finished_q, finished_d;
    logic              dly_tc_s;

    // The counter reloads during LOAD_START so it reads zero on the first delay cycle.
    generate
        if (DELAY_CYCLES > 0) begin : g_delay
            op_sequencer_cycle_counter #(
                .LIMIT (DELAY_CYCLES)
            ) u_delay (
                .clock  (clock),
                .reset  (reset),
                .load   (state_q == OPSEQ_LOAD_START),
                .enable (state_q == OPSEQ_LOAD_DELAY),
                .tc     (dly_tc_s)
            );
        end else begin : g_no_delay
            assign dly_tc_s = 1'b1;
        end
    endgenerate

`ifdef OPSEQ_TIMEOUT_EN
    logic tmo_tc_s;
    logic error_q, error_d;

    op_sequencer_cycle_counter #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .load   (state_q != OPSEQ_LOAD_WAIT),
        .enable (state_q == OPSEQ_LOAD_WAIT),
        .tc     (tmo_tc_s)
    );
`endif

    // Next-state, index and output computation.
    always_comb begin
        state_d    = state_q;
        iter_lat_d = iter_lat_q;
        step_idx_d = step_idx_q;
        iter_idx_d = iter_idx_q;
        pending_d  = pending_q;
`ifdef OPSEQ_TIMEOUT_EN
        error_d    = error_q;
`endif
        case (state_q)
            OPSEQ_IDLE: begin
                pending_d = 1'b0;
                if (start) begin
                    iter_lat_d = iterations;
                    state_d    = OPSEQ_LOAD_START;
`ifdef OPSEQ_TIMEOUT_EN
                    error_d    = 1'b0;
`endif
                end else begin
                    state_d = OPSEQ_IDLE;
                end
            end
            // A zero count still passes through here, with step_go suppressed.
            OPSEQ_LOAD_START: begin
                if (iter_lat_q == {ITER_W{1'b0}}) begin
                    pending_d = 1'b0;
                    state_d   = OPSEQ_DONE;
                end else begin
                    pending_d = pending_q | step_done;
                    state_d   = (DELAY_CYCLES == 0) ? OPSEQ_LOAD_WAIT : OPSEQ_LOAD_DELAY;
                end
            end
            OPSEQ_LOAD_DELAY: begin
                pending_d = pending_q | step_done;
                if (dly_tc_s) begin
                    state_d = OPSEQ_LOAD_WAIT;
                end else begin
                    state_d = OPSEQ_LOAD_DELAY;
                end
            end
            OPSEQ_LOAD_WAIT: begin
                if (step_done || pending_q) begin
                    pending_d = 1'b0;
                    if (step_idx_q != STEP_W'(N_STEPS - 1)) begin
                        step_idx_d = step_idx_q + STEP_W'(1);
                        state_d    = OPSEQ_LOAD_START;
                    end else if (iter_idx_q < (iter_lat_q - ITER_W'(1))) begin
                        step_idx_d = {STEP_W{1'b0}};
                        iter_idx_d = iter_idx_q + ITER_W'(1);
                        state_d    = OPSEQ_LOAD_START;
                    end else begin
                        state_d = OPSEQ_DONE;
                    end
                end
`ifdef OPSEQ_TIMEOUT_EN
                else if (tmo_tc_s) begin
                    error_d = 1'b1;
                    state_d = OPSEQ_DONE;
                end
`endif
                else begin
                    state_d = OPSEQ_LOAD_WAIT;
                end
            end
            OPSEQ_DONE: begin
                step_idx_d = {STEP_W{1'b0}};
                iter_idx_d = {ITER_W{1'b0}};
                state_d    = OPSEQ_IDLE;
            end
            default: begin
                pending_d  = 1'b0;
                step_idx_d = {STEP_W{1'b0}};
                iter_idx_d = {ITER_W{1'b0}};
                state_d    = OPSEQ_IDLE;
            end
        endcase

        busy_d     = (state_d != OPSEQ_IDLE);
        step_go_d  = (state_d == OPSEQ_LOAD_START) &&
                     !((state_q == OPSEQ_IDLE) && (iterations == {ITER_W{1'b0}}));
        finished_d = (state_d == OPSEQ_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= OPSEQ_IDLE;
            iter_lat_q <= {ITER_W{1'b0}};
            step_idx_q <= {STEP_W{1'b0}};
            iter_idx_q <= {ITER_W{1'b0}};
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
            step_go_q  <= 1'b0;
            finished_q <= 1'b0;
`ifdef OPSEQ_TIMEOUT_EN
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            iter_lat_q <= iter_lat_d;
            step_idx_q <= step_idx_d;
            iter_idx_q <= iter_idx_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
            step_go_q  <= step_go_d;
            finished_q <= finished_d;
`ifdef OPSEQ_TIMEOUT_EN
            error_q    <= error_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign step_go  = step_go_q;
    assign step_idx = step_idx_q;
    assign iter_idx = iter_idx_q;
    assign finished = finished_q;
`ifdef OPSEQ_TIMEOUT_EN
    assign error    = error_q;
`else
    assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: a planned step_done schedule yields the
// expected step_go/finished/busy timeline per run. Timeout case runs under OPSEQ_TIMEOUT_EN.
module tb_op_sequencer;

    localparam int N_STEPS = 3;
    localparam int STEP_W  = 2;
    localparam int ITER_W  = 4;
    localparam int DLY     = 2;
    localparam int TMO     = 10;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ITER_W-1:0] iterations;
    logic              step_done;
    logic              busy;
    logic              step_go;
    logic [STEP_W-1:0] step_idx;
    logic [ITER_W-1:0] iter_idx;
    logic              finished;
    logic              error;

    int n_cmp  = 0;
    int n_fail = 0;

    op_sequencer #(
        .N_STEPS      (N_STEPS),
        .STEP_W       (STEP_W),
        .ITER_W       (ITER_W),
        .DELAY_CYCLES (DLY),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .iterations (iterations),
        .step_done  (step_done),
        .busy       (busy),
        .step_go    (step_go),
        .step_idx   (step_idx),
        .iter_idx   (iter_idx),
        .finished   (finished),
        .error      (error)
    );

    always #5 clock = ~clock;

    // One run: cycle 0 presents start; each step's go lands at cycle t, its
    // step_done k cycles later; the next go follows max(k, DLY+1)+1 after t.
    // mode 0: k = DLY+2, mode 1: k random 1..DLY+4, mode 2: k inside the delay.
    task automatic run_seq(input int iters, input int mode, input bit noise);
        int go_cyc[$];
        int go_step[$];
        int go_iter[$];
        bit done_at[0:1023];
        bit start_at[0:1023];
        int t;
        int k;
        int fin;
        int gi;
        bit exp_go;
        t  = 1;
        gi = 0;
        for (int i = 0; i < iters; i++) begin
            for (int s = 0; s < N_STEPS; s++) begin
                go_cyc.push_back(t);
                go_step.push_back(s);
                go_iter.push_back(i);
                if (mode == 0) k = DLY + 2;
                else if (mode == 1) k = $urandom_range(DLY + 4, 1);
                else k = $urandom_range(DLY, 1);
                done_at[t + k] = 1'b1;
                t = t + ((k > DLY + 1) ? k : DLY + 1) + 1;
            end
        end
        fin = (iters == 0) ? 2 : t;
        if (noise) begin
            for (int c = 1; c <= fin; c++) start_at[c] = ($urandom_range(3, 0) == 0);
            done_at[0] = 1'b1;
            if (iters > 0) done_at[fin] = 1'b1;
        end
        @(negedge clock);
        iterations = ITER_W'(iters);
        start      = 1'b1;
        step_done  = done_at[0];
        for (int c = 1; c <= fin + 1; c++) begin
            @(negedge clock);
            exp_go = (gi < go_cyc.size()) && (go_cyc[gi] == c);
            n_cmp++;
            if (step_go !== exp_go) begin
                n_fail++;
                $display("FAIL step_go iters=%0d cycle=%0d got=%0b expected=%0b", iters, c, step_go, exp_go);
            end
            if (exp_go) begin
                n_cmp++;
                if (step_idx !== STEP_W'(go_step[gi]) || iter_idx !== ITER_W'(go_iter[gi])) begin
                    n_fail++;
                    $display("FAIL step_index cycle=%0d got=%0d/%0d expected=%0d/%0d", c, step_idx, iter_idx, go_step[gi], go_iter[gi]);
                end
                gi++;
            end
            n_cmp++;
            if (finished !== (c == fin)) begin
                n_fail++;
                $display("FAIL finished iters=%0d cycle=%0d got=%0b expected=%0b", iters, c, finished, (c == fin));
            end
            n_cmp++;
            if (busy !== (c <= fin)) begin
                n_fail++;
                $display("FAIL busy iters=%0d cycle=%0d got=%0b expected=%0b", iters, c, busy, (c <= fin));
            end
            n_cmp++;
            if (error !== 1'b0) begin
                n_fail++;
                $display("FAIL error_low cycle=%0d got=%0b expected=0", c, error);
            end
            if (c == fin + 1) begin
                n_cmp++;
                if (step_idx !== '0 || iter_idx !== '0) begin
                    n_fail++;
                    $display("FAIL idle_index got=%0d/%0d expected=0/0", step_idx, iter_idx);
                end
            end
            start      = start_at[c];
            step_done  = done_at[c];
            iterations = ITER_W'($urandom);
        end
        start     = 1'b0;
        step_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; step_done = 1'b0; iterations = '0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({busy, step_go, finished, error} !== 4'b0000 || step_idx !== '0 || iter_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_state got=%b/%0d/%0d expected=0000/0/0", {busy, step_go, finished, error}, step_idx, iter_idx);
        end
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset got=%0b expected=0", busy);
        end
    endtask

    task automatic test_single_iter();
        run_seq(1, 0, 1'b0);
    endtask

    task automatic test_two_iter();
        run_seq(2, 0, 1'b0);
        run_seq(2, 1, 1'b0);
    endtask

    task automatic test_zero_iter();
        run_seq(0, 0, 1'b0);
        run_seq(0, 0, 1'b1);
    endtask

    task automatic test_pending();
        run_seq(1, 2, 1'b0);
        run_seq(2, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) run_seq($urandom_range(3, 1), 1, r[0]);
        run_seq(15, 1, 1'b0);
    endtask

    task automatic test_start_mid();
        run_seq(2, 1, 1'b1);
        run_seq(1, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        iterations = 4'd2;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_cmp++;
        if (step_go !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_go got=%0b expected=1", step_go);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_cmp++;
        if ({busy, step_go, finished, error} !== 4'b0000 || step_idx !== '0 || iter_idx !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got=%b/%0d/%0d expected=0000/0/0", {busy, step_go, finished, error}, step_idx, iter_idx);
        end
        @(negedge clock);
        n_cmp++;
        if (busy !== 1'b0 || step_go !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_idle got=%0b%0b expected=00", busy, step_go);
        end
        run_seq(1, 1, 1'b0);
    endtask

`ifdef OPSEQ_TIMEOUT_EN
    // go at 1, delay 2..3, WAIT 4..13, DONE at 14 with error raised.
    task automatic test_timeout();
        @(negedge clock);
        iterations = 4'd1;
        start      = 1'b1;
        step_done  = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            start = 1'b0;
            n_cmp++;
            if (finished !== (c == 14) || busy !== (c <= 14) || error !== (c >= 14)) begin
                n_fail++;
                $display("FAIL timeout cycle=%0d got fin/busy/err=%0b%0b%0b expected=%0b%0b%0b",
                         c, finished, busy, error, (c == 14), (c <= 14), (c >= 14));
            end
        end
        run_seq(1, 1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_single_iter();
        test_two_iter();
        test_zero_iter();
        test_pending();
        test_start_mid();
        test_random();
        test_reset_mid();
`ifdef OPSEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
